rs_syndrome: RTL

RS_SYNDROME -- requirements
Module: rs_syndrome

---
 rtl/rs_syndrome.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rs_syndrome.sv
// Streaming Reed-Solomon syndrome calculator: one Horner accumulator per root
// alpha^(FCR+j), with a separate output bank that is loaded at each frame end.
package gf_pkg;
    localparam int unsigned SYMB_WIDTH = 8;
    localparam int unsigned ROOTS_NUM  = 16;
    localparam int unsigned N_LEN      = 255;
    localparam logic [SYMB_WIDTH:0] GF_POLY = 9'h11D;

    function automatic logic [SYMB_WIDTH-1:0] gf_mul(input logic [SYMB_WIDTH-1:0] a,
                                                     input logic [SYMB_WIDTH-1:0] b);
        logic [SYMB_WIDTH-1:0] p;
        logic [SYMB_WIDTH-1:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) p = p ^ x;
            x = x[SYMB_WIDTH-1] ? ((x << 1) ^ GF_POLY[SYMB_WIDTH-1:0]) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [SYMB_WIDTH-1:0] gf_alpha_pow(input int unsigned e);
        logic [SYMB_WIDTH-1:0] r;
        r    = '0;
        r[0] = 1'b1;
        for (int unsigned i = 0; i < e % ((1 << SYMB_WIDTH) - 1); i++)
            r = gf_mul(r, SYMB_WIDTH'(2));
        return r;
    endfunction
endpackage

module rs_syndrome
    import gf_pkg::*;
#(
    parameter int unsigned FCR = 0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [SYMB_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [SYMB_WIDTH-1:0] syndrome [ROOTS_NUM-1:0],
    output logic                  syndrome_vld,
    output logic                  syndrome_nz,
    output logic                  frame_err
);
    localparam int unsigned      CNT_W   = $clog2(N_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_LEN);

    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state_q, state_d;

    logic [SYMB_WIDTH-1:0] acc_q   [ROOTS_NUM-1:0];
    logic [SYMB_WIDTH-1:0] acc_mul [ROOTS_NUM-1:0];
    logic [SYMB_WIDTH-1:0] acc_d   [ROOTS_NUM-1:0];
    logic [CNT_W-1:0]      cnt_q, cnt_inc;
    logic                  over_q, over_inc;
    logic                  accept, first_beat, frame_end, acc_nz;

    assign accept = s_tvalid & s_tready;

    for (genvar g = 0; g < ROOTS_NUM; g++) begin : g_root
        localparam logic [SYMB_WIDTH-1:0] ROOT = gf_alpha_pow(FCR + g);
        assign acc_mul[g] = gf_mul(acc_q[g], ROOT);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !s_tlast) state_d = ACCUM;
            ACCUM:   if (accept && s_tlast)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        first_beat = accept && (state_q == IDLE);
        frame_end  = accept && s_tlast;
    end

    always_comb begin
        acc_nz = 1'b0;
        for (int unsigned j = 0; j < ROOTS_NUM; j++) begin
            acc_d[j] = first_beat ? s_tdata : (acc_mul[j] ^ s_tdata);
            acc_nz   = acc_nz | (|acc_d[j]);
        end
    end

    // cnt_q is already 0 in IDLE (cleared at frame end), so no per-state base mux.
    // over_q remembers a count that ran past N_LEN while the counter sat saturated.
    always_comb begin
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        over_inc = over_q | (cnt_q == CNT_MAX);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_tready     <= 1'b0;
            cnt_q        <= '0;
            over_q       <= 1'b0;
            syndrome_vld <= 1'b0;
            syndrome_nz  <= 1'b0;
            frame_err    <= 1'b0;
            for (int unsigned j = 0; j < ROOTS_NUM; j++) begin
                acc_q[j]    <= '0;
                syndrome[j] <= '0;
            end
        end else begin
            s_tready     <= 1'b1;
            syndrome_vld <= frame_end;
            if (accept) begin
                for (int unsigned j = 0; j < ROOTS_NUM; j++) acc_q[j] <= acc_d[j];
                if (s_tlast) begin
                    cnt_q       <= '0;
                    over_q      <= 1'b0;
                    syndrome_nz <= acc_nz;
                    frame_err   <= over_inc | (cnt_inc != CNT_MAX);
                    for (int unsigned j = 0; j < ROOTS_NUM; j++) syndrome[j] <= acc_d[j];
                end else begin
                    cnt_q  <= cnt_inc;
                    over_q <= over_inc;
                end
            end
        end
    end
endmodule
